// File: rtl/pixel_stream_pkg.sv
// Shared types and widths for the synthetic camera-stream transmitter.
package pixel_stream_pkg;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned CNT_W = 10;
    localparam int unsigned FRM_W = 16;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    typedef enum logic [1:0] {PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_VEDGE} pattern_t;

endpackage

// File: rtl/pixel_stream_if.sv
// Pixel data/valid bus as seen by the convolution stage and its line buffer.
interface pixel_stream_if;
    import pixel_stream_pkg::*;

    logic [PIX_W-1:0] oDATA;
    logic             oDVAL;
    logic             oFVAL;
    logic [CNT_W-1:0] oX_Cont;
    logic [CNT_W-1:0] oY_Cont;

    modport master (output oDATA, oDVAL, oFVAL, oX_Cont, oY_Cont);
    modport slave  (input  oDATA, oDVAL, oFVAL, oX_Cont, oY_Cont);

endinterface

// File: rtl/pixel_stream_gen_pattern.sv
// Combinational test-pattern lookup: (pattern, column, row) -> raw pixel.
module pixel_pattern
    import pixel_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640
) (
    input  pattern_t         pat_i,
    input  logic [CNT_W-1:0] x_i,
    input  logic [CNT_W-1:0] y_i,
    output logic [PIX_W-1:0] pixel_c_o
);

    localparam logic [CNT_W-1:0] X_HALF = CNT_W'(H_ACTIVE / 2);

    always_comb begin
        pixel_c_o = '0;
        case (pat_i)
            PAT_HRAMP: pixel_c_o = PIX_W'({x_i, 2'b00});
            PAT_VRAMP: pixel_c_o = PIX_W'({y_i, 2'b00});
            PAT_CHECK: pixel_c_o = (x_i[3] ^ y_i[3]) ? '1 : '0;
            PAT_VEDGE: pixel_c_o = (x_i >= X_HALF) ? '1 : '0;
            default:   pixel_c_o = '0;
        endcase
    end

endmodule

// File: rtl/pixel_stream_gen.sv
// Raster timing FSM, counters and registered outputs for the test-pattern stream.
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_BLANK  = 4
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic             iStop,
    input  logic [1:0]       iPattern,
    output logic [FRM_W-1:0] oFrame_Cont,
    output logic             oBusy,
    pixel_stream_if.master   vid
);

    localparam int unsigned LINE_CYC = H_ACTIVE + H_BLANK;
    localparam int unsigned VB_CYC   = V_BLANK * LINE_CYC;
    localparam int unsigned BCNT_W   = $clog2(VB_CYC);

    localparam logic [CNT_W-1:0]  X_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  Y_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [BCNT_W-1:0] HB_LAST = BCNT_W'(H_BLANK - 1);
    localparam logic [BCNT_W-1:0] VB_LAST = BCNT_W'(VB_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    pattern_t          pat_q, pat_d;
    logic              stop_q, stop_d;
    logic              start_block_q, start_block_d;
    logic [FRM_W-1:0]  frame_q, frame_d;

    logic [PIX_W-1:0]  data_q;
    logic              dval_q, fval_q, busy_q;
    logic [CNT_W-1:0]  xo_q, yo_q;
    logic [FRM_W-1:0]  frame_o_q;
    logic [PIX_W-1:0]  pixel_c;

    pixel_pattern #(.H_ACTIVE(H_ACTIVE)) u_pattern (
        .pat_i     (pat_q),
        .x_i       (x_q),
        .y_i       (y_q),
        .pixel_c_o (pixel_c)
    );

    // A stop leaves start blocked until iStart is released, so a held iStart cannot restart.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        bcnt_d        = bcnt_q;
        pat_d         = pat_q;
        stop_d        = stop_q;
        start_block_d = start_block_q;
        frame_d       = frame_q;

        if (state_q != IDLE && iStop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                x_d    = '0;
                y_d    = '0;
                bcnt_d = '0;
                if (!iStart) begin
                    start_block_d = 1'b0;
                end
                if (iStart && !iStop && !start_block_q) begin
                    state_d = ACTIVE;
                    pat_d   = pattern_t'(iPattern);
                end
            end
            ACTIVE: begin
                if (x_q == X_LAST) begin
                    state_d = HBLANK;
                    bcnt_d  = '0;
                end else begin
                    x_d = x_q + CNT_W'(1);
                end
            end
            HBLANK: begin
                if (bcnt_q == HB_LAST) begin
                    bcnt_d = '0;
                    x_d    = '0;
                    if (y_q == Y_LAST) begin
                        state_d = VBLANK;
                        y_d     = '0;
                    end else begin
                        state_d = ACTIVE;
                        y_d     = y_q + CNT_W'(1);
                    end
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            VBLANK: begin
                if (bcnt_q == VB_LAST) begin
                    bcnt_d  = '0;
                    frame_d = frame_q + FRM_W'(1);
                    if (stop_q || iStop) begin
                        state_d       = IDLE;
                        stop_d        = 1'b0;
                        start_block_d = 1'b1;
                    end else begin
                        state_d = ACTIVE;
                        pat_d   = pattern_t'(iPattern);
                    end
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            bcnt_q        <= '0;
            pat_q         <= PAT_HRAMP;
            stop_q        <= 1'b0;
            start_block_q <= 1'b0;
            frame_q       <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            bcnt_q        <= bcnt_d;
            pat_q         <= pat_d;
            stop_q        <= stop_d;
            start_block_q <= start_block_d;
            frame_q       <= frame_d;
        end
    end

    // Output stage: one register slice behind the raster state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            data_q    <= '0;
            dval_q    <= 1'b0;
            fval_q    <= 1'b0;
            xo_q      <= '0;
            yo_q      <= '0;
            busy_q    <= 1'b0;
            frame_o_q <= '0;
        end else begin
            data_q    <= (state_q == ACTIVE) ? pixel_c : '0;
            dval_q    <= (state_q == ACTIVE);
            fval_q    <= (state_q == ACTIVE) || (state_q == HBLANK);
            xo_q      <= x_q;
            yo_q      <= y_q;
            busy_q    <= (state_q != IDLE);
            frame_o_q <= frame_q;
        end
    end

    assign vid.oDATA   = data_q;
    assign vid.oDVAL   = dval_q;
    assign vid.oFVAL   = fval_q;
    assign vid.oX_Cont = xo_q;
    assign vid.oY_Cont = yo_q;
    assign oBusy       = busy_q;
    assign oFrame_Cont = frame_o_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Scoreboard bench for pixel_stream_gen: expected pixels queued per frame, checked by a monitor.
module tb_pixel_stream_gen;
    import pixel_stream_pkg::*;

    localparam int H = 8, V = 4, HB = 2, VB = 1;
    localparam int LINE = H + HB;
    localparam int FRAME = (V + VB) * LINE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [15:0] fc;
    logic        busy;

    pixel_stream_if vid();

    pixel_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .iStop(stop), .iPattern(pat),
        .oFrame_Cont(fc), .oBusy(busy), .vid(vid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] d;
        logic [9:0]  x;
        logic [9:0]  y;
    } pix_t;

    pix_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_frames = 0;

    function automatic logic [11:0] ref_pix(int p, int x, int y);
        case (p)
            0:       return 12'((x * 4) % 4096);
            1:       return 12'((y * 4) % 4096);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
            default: return (x >= H / 2) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int p);
        pix_t e;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                e.d = ref_pix(p, x, y);
                e.x = 10'(x);
                e.y = 10'(y);
                exp_q.push_back(e);
            end
        exp_frames++;
    endtask

    // Monitor: pixel scoreboard plus line, blank and frame-length tracking.
    int trk_ok = 0, hi_run = 0, lo_run = 0, lo_ok = 0, fv_run = 0, fv_ok = 0;
    bit prev_dval = 0, prev_fval = 0;
    initial begin
        pix_t e;
        forever begin
            @(negedge clk);
            if (rst) trk_ok = 0;
            if (vid.oDVAL) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pixel_unexpected: x=%0d y=%0d data=0x%0h", vid.oX_Cont, vid.oY_Cont, vid.oDATA);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 32'(vid.oDATA), 32'(e.d));
                    check("pix_x", 32'(vid.oX_Cont), 32'(e.x));
                    check("pix_y", 32'(vid.oY_Cont), 32'(e.y));
                end
                check("fval_with_dval", 32'(vid.oFVAL), 1);
                if (!prev_dval) begin
                    if (lo_ok != 0)
                        check("blank_len", lo_run, (vid.oY_Cont == 0) ? HB + VB * LINE : HB);
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                check("data_zero_blank", 32'(vid.oDATA), 0);
                if (vid.oFVAL) check("hblank_x_hold", 32'(vid.oX_Cont), H - 1);
                else begin
                    check("x_zero_outside", 32'(vid.oX_Cont), 0);
                    check("y_zero_outside", 32'(vid.oY_Cont), 0);
                end
                if (prev_dval) begin
                    if (trk_ok != 0) check("line_len", hi_run, H);
                    lo_run = 0;
                    lo_ok = trk_ok;
                end
                lo_run++;
                if (!busy || trk_ok == 0) lo_ok = 0;
            end
            if (vid.oFVAL) begin
                if (!prev_fval) begin
                    fv_run = 0;
                    fv_ok = trk_ok;
                end
                fv_run++;
            end else if (prev_fval && fv_ok != 0 && trk_ok != 0) begin
                check("fval_len", fv_run, V * LINE);
            end
            prev_dval = vid.oDVAL;
            prev_fval = vid.oFVAL;
            if (!busy && !rst) trk_ok = 1;
        end
    end

    task automatic wait_pixel(input int x, input int y, input int budget);
        int c = 0;
        bit hit = 0;
        while (!hit && c < budget) begin
            @(negedge clk);
            c++;
            hit = vid.oDVAL && (vid.oX_Cont == 10'(x)) && (vid.oY_Cont == 10'(y));
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_pixel: x=%0d y=%0d not seen within %0d cycles", x, y, budget);
        end
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: oBusy still 1 after %0d cycles", budget);
        end
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(vid.oDATA), 0);
        check({tag, "_dval"}, 32'(vid.oDVAL), 0);
        check({tag, "_fval"}, 32'(vid.oFVAL), 0);
        check({tag, "_x"}, 32'(vid.oX_Cont), 0);
        check({tag, "_y"}, 32'(vid.oY_Cont), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frames"}, 32'(fc), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b0;
        exp_q.delete();
        exp_frames = 0;
    endtask

    task automatic end_of_run(input string tag);
        check({tag, "_frames"}, 32'(fc), 32'(exp_frames));
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, p, hold;

        // Single start pulse, horizontal ramp, stop in line 2.
        do_reset();
        pat = 2'd0;
        push_frame(0);
        pulse_start();
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("lat_dval", 32'(vid.oDVAL), 1);
                check("lat_fval", 32'(vid.oFVAL), 1);
                check("lat_busy", 32'(busy), 1);
            end
            if (c == 8) check("last_px_dval", 32'(vid.oDVAL), 1);
            if (c == 9) check("first_hb_dval", 32'(vid.oDVAL), 0);
            if (c == 50) begin
                check("c50_busy", 32'(busy), 1);
                check("c50_frames", 32'(fc), 0);
            end
            if (c == 51) begin
                check("c51_busy", 32'(busy), 0);
                check("c51_frames", 32'(fc), 1);
            end
            #1 stop = (c == 25);
        end
        stop = 1'b0;
        end_of_run("s1");

        // Held start, vertical edge, two back-to-back frames, then stop with start still high.
        do_reset();
        pat = 2'd3;
        push_frame(3);
        push_frame(3);
        start = 1'b1;
        wait_pixel(0, 0, 20);
        wait_pixel(0, 0, FRAME + 5);
        wait_pixel(3, 2, FRAME);
        pulse_stop();
        wait_idle(FRAME);
        end_of_run("s2");
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("held_start_dval", 32'(vid.oDVAL), 0);
            check("held_start_busy", 32'(busy), 0);
        end
        #1 start = 1'b0;

        // Start and stop together in IDLE: stop wins.
        do_reset();
        start = 1'b1;
        stop = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check("both_busy", 32'(busy), 0);
            check("both_dval", 32'(vid.oDVAL), 0);
        end
        #1 start = 1'b0;
        stop = 1'b0;

        // Pattern changed mid-frame applies only from the next frame.
        do_reset();
        pat = 2'd1;
        push_frame(1);
        pulse_start();
        wait_pixel(2, 1, 30);
        pat = 2'd2;
        push_frame(2);
        wait_pixel(0, 0, FRAME);
        wait_pixel(4, 1, 30);
        pulse_stop();
        wait_idle(FRAME);
        end_of_run("s5");

        // Reset mid-line, then restart from the origin.
        do_reset();
        pat = 2'd0;
        push_frame(0);
        pulse_start();
        wait_pixel(5, 1, 30);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midline_rst");
        #1 rst = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        push_frame(0);
        pulse_start();
        @(negedge clk);
        check("restart_dval", 32'(vid.oDVAL), 1);
        check("restart_x", 32'(vid.oX_Cont), 0);
        check("restart_y", 32'(vid.oY_Cont), 0);
        #1;
        wait_pixel(2, 2, 40);
        pulse_stop();
        wait_idle(FRAME);
        end_of_run("s6");

        // Randomized runs: random patterns, frame counts, stop points, pulse or held start.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            nf = int'($urandom_range(1, 3));
            p = int'($urandom_range(0, 3));
            hold = int'($urandom_range(0, 1));
            pat = 2'(p);
            push_frame(p);
            if (hold != 0) start = 1'b1;
            else pulse_start();
            wait_pixel(0, 0, 20);
            for (int f = 1; f < nf; f++) begin
                wait_pixel(int'($urandom_range(0, H - 1)), int'($urandom_range(1, V - 1)), FRAME);
                p = int'($urandom_range(0, 3));
                pat = 2'(p);
                push_frame(p);
                wait_pixel(0, 0, FRAME);
            end
            wait_pixel(int'($urandom_range(0, H - 1)), int'($urandom_range(1, V - 1)), FRAME);
            pulse_stop();
            pat = 2'($urandom_range(0, 3));
            wait_idle(FRAME);
            end_of_run("rand");
            start = 1'b0;
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
